// File: rtl/ex_wb_stage.sv
// Purpose : EX->WB pipeline register that holds loads until memory returns data.
// Latency : ALU results write back 1 cycle after acceptance; loads write back 1 cycle after MEM_RDY.
// Backpr. : STALL is high for every cycle a load waits on memory; upstream holds its instruction.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   IN_VALID/IN_WC/IN_WE/IN_LOAD/IN_RES - instruction arriving from EX
//   MEM_RDY/MEM_DATA - memory read return (only looked at while a load waits)
//   FLUSH           - synchronous flush, overrides everything else
//   STALL           - upstream must hold (pure function of state)
//   WC/W_RB/WDATA   - registered writeback index / enable / data
//   STALL_CNT       - saturating count of stalled cycles
//
// Build option: define EX_WB_R0_SUPPRESS_EN to never assert W_RB for register 0.

module ex_wb_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          IN_VALID,
  input  logic [3:0]    IN_WC,
  input  logic          IN_WE,
  input  logic          IN_LOAD,
  input  logic [DW-1:0] IN_RES,
  input  logic          MEM_RDY,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          FLUSH,
  output logic          STALL,
  output logic [3:0]    WC,
  output logic          W_RB,
  output logic [DW-1:0] WDATA,
  output logic [7:0]    STALL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALU    = 2'd1,
    S_WAIT   = 2'd2,
    S_LOADED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    wc_q, wc_d;
  logic          w_rb_q, w_rb_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    stall_cnt_q, stall_cnt_d;

  logic          stall;
  logic          is_load;

  // A load only needs to wait for memory if it actually writes a register.
  assign is_load = IN_LOAD & IN_WE;

  // ---------------------------------------------------------------------------
  // State register (also holds the registered writeback outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wc_q        <= 4'd0;
      w_rb_q      <= 1'b0;
      wdata_q     <= '0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      w_rb_q      <= w_rb_d;
      wdata_q     <= wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = S_IDLE;
    end else if (state_q == S_WAIT) begin
      // Upstream is held, so IN_* is irrelevant until memory answers.
      state_d = MEM_RDY ? S_LOADED : S_WAIT;
    end else if (!IN_VALID) begin
      state_d = S_IDLE;
    end else if (is_load) begin
      state_d = S_WAIT;
    end else begin
      state_d = S_ALU;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wc_d        = wc_q;
    wdata_d     = wdata_q;
    w_rb_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;

    // A flushed cycle is not counted as a stall; saturate rather than wrap.
    if (stall && !FLUSH && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end

    if (!FLUSH) begin
      if (state_q == S_WAIT) begin
        if (MEM_RDY) begin
          wdata_d = MEM_DATA;
          w_rb_d  = 1'b1;
        end
      end else if (IN_VALID) begin
        // The index is captured immediately even for loads so the forward
        // unit can see which register is pending.
        wc_d = IN_WC;
        if (!is_load) begin
          wdata_d = IN_RES;
          w_rb_d  = IN_WE;
        end
      end
    end

`ifdef EX_WB_R0_SUPPRESS_EN
    // Register 0 is hardwired: never write it and never forward it.
    if (wc_d == 4'd0) begin
      w_rb_d = 1'b0;
    end
`endif
  end

  // STALL depends only on the current state, never directly on inputs.
  assign stall = (state_q == S_WAIT);

  assign STALL     = stall;
  assign WC        = wc_q;
  assign W_RB      = w_rb_q;
  assign WDATA     = wdata_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the writeback rules.
module tb_ex_wb_stage;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [3:0]    in_wc;
  logic          in_we;
  logic          in_load;
  logic [DW-1:0] in_res;
  logic          mem_rdy;
  logic [DW-1:0] mem_data;
  logic          flush;
  logic          stall;
  logic [3:0]    wc;
  logic          w_rb;
  logic [DW-1:0] wdata;
  logic [7:0]    stall_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: "a load is outstanding" plus the expected outputs.
  bit            m_pending;
  logic [3:0]    m_wc;
  logic          m_wrb;
  logic [DW-1:0] m_wdata;
  int            m_cnt;

  ex_wb_stage #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IN_VALID  (in_valid),
    .IN_WC     (in_wc),
    .IN_WE     (in_we),
    .IN_LOAD   (in_load),
    .IN_RES    (in_res),
    .MEM_RDY   (mem_rdy),
    .MEM_DATA  (mem_data),
    .FLUSH     (flush),
    .STALL     (stall),
    .WC        (wc),
    .W_RB      (w_rb),
    .WDATA     (wdata),
    .STALL_CNT (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_wc      = 4'd0;
    m_wrb     = 1'b0;
    m_wdata   = '0;
    m_cnt     = 0;
  endtask

  // One clock edge of the writeback rules, using the inputs present at the edge.
  task automatic model_edge();
    if (flush) begin
      m_pending = 1'b0;
      m_wrb     = 1'b0;
    end else if (m_pending) begin
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (mem_rdy) begin
        m_pending = 1'b0;
        m_wdata   = mem_data;
        m_wrb     = 1'b1;
      end else begin
        m_wrb = 1'b0;
      end
    end else if (!in_valid) begin
      m_wrb = 1'b0;
    end else if (in_load && in_we) begin
      m_pending = 1'b1;
      m_wc      = in_wc;
      m_wrb     = 1'b0;
    end else begin
      m_wc    = in_wc;
      m_wdata = in_res;
      m_wrb   = in_we;
    end
`ifdef EX_WB_R0_SUPPRESS_EN
    if (m_wc == 4'd0) m_wrb = 1'b0;
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wc"},    {28'd0, wc},         {28'd0, m_wc});
    check({tag, ".w_rb"},  {31'd0, w_rb},       {31'd0, m_wrb});
    check({tag, ".wdata"}, {16'd0, wdata},      {16'd0, m_wdata});
    check({tag, ".stall"}, {31'd0, stall},      {31'd0, m_pending});
    check({tag, ".cnt"},   {24'd0, stall_cnt},  m_cnt);
  endtask

  // Drive inputs on the falling edge, advance one rising edge, check on the next falling edge.
  task automatic step(input string tag, input logic v, input logic [3:0] i_wc,
                      input logic we, input logic ld, input logic [DW-1:0] res,
                      input logic mr, input logic [DW-1:0] md, input logic fl);
    in_valid = v;  in_wc = i_wc;  in_we = we;  in_load = ld;  in_res = res;
    mem_rdy  = mr; mem_data = md; flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_wc = 0; in_we = 0; in_load = 0; in_res = 0;
    mem_rdy = 0; mem_data = 0; flush = 0;
    model_reset();
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("post_reset");

    // ALU path
    step("alu", 1, 4'd5, 1, 0, 16'h1234, 0, 16'h0, 0);
    check("alu_wc", {28'd0, wc}, 32'd5);
    check("alu_wrb", {31'd0, w_rb}, 32'd1);
    check("alu_wdata", {16'd0, wdata}, 32'h1234);
    check("alu_stall", {31'd0, stall}, 32'd0);

    // Load with 3-cycle memory delay
    step("ld_issue", 1, 4'd7, 1, 1, 16'h5555, 0, 16'h0, 0);
    check("ld_stall1", {31'd0, stall}, 32'd1);
    check("ld_wrb1", {31'd0, w_rb}, 32'd0);
    step("ld_wait2", 0, 4'd0, 0, 0, 16'h0, 0, 16'h1111, 0);
    check("ld_stall2", {31'd0, stall}, 32'd1);
    check("ld_wrb2", {31'd0, w_rb}, 32'd0);
    step("ld_wait3", 0, 4'd0, 0, 0, 16'h0, 0, 16'h2222, 0);
    check("ld_stall3", {31'd0, stall}, 32'd1);
    step("ld_ret", 0, 4'd0, 0, 0, 16'h0, 1, 16'hBEEF, 0);
    check("ld_wrb", {31'd0, w_rb}, 32'd1);
    check("ld_wdata", {16'd0, wdata}, 32'hBEEF);
    check("ld_wc", {28'd0, wc}, 32'd7);
    check("ld_cnt", {24'd0, stall_cnt}, 32'd3);
    check("ld_stall_off", {31'd0, stall}, 32'd0);
    step("ld_idle", 0, 4'd0, 0, 0, 16'h0, 0, 16'h0, 0);
    check("ld_idle_wrb", {31'd0, w_rb}, 32'd0);

    // FLUSH and MEM_RDY together while waiting
    step("fl_issue", 1, 4'd3, 1, 1, 16'h0, 0, 16'h0, 0);
    step("fl_edge", 0, 4'd0, 0, 0, 16'h0, 1, 16'hDEAD, 1);
    check("fl_wrb", {31'd0, w_rb}, 32'd0);
    check("fl_stall", {31'd0, stall}, 32'd0);
    check("fl_wdata", {16'd0, wdata}, 32'hBEEF);
    check("fl_cnt", {24'd0, stall_cnt}, 32'd3);
    step("fl_after", 0, 4'd0, 0, 0, 16'h0, 1, 16'hDEAD, 0);
    check("fl_ignore_rdy", {16'd0, wdata}, 32'hBEEF);

    // STALL_CNT saturation
    step("sat_issue", 1, 4'd9, 1, 1, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 300; i++) begin
      step("sat_hold", 0, 4'd0, 0, 0, 16'h0, 0, 16'h0, 0);
    end
    check("sat_cnt", {24'd0, stall_cnt}, 32'd255);
    check("sat_stall", {31'd0, stall}, 32'd1);
    step("sat_flush", 0, 4'd0, 0, 0, 16'h0, 0, 16'h0, 1);
    check("sat_cnt_hold", {24'd0, stall_cnt}, 32'd255);

    // Asynchronous reset mid-WAIT, between clock edges
    step("rst_issue", 1, 4'd6, 1, 1, 16'h0, 0, 16'h0, 0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wc", {28'd0, wc}, 32'd0);
    check("rst_wrb", {31'd0, w_rb}, 32'd0);
    check("rst_wdata", {16'd0, wdata}, 32'd0);
    check("rst_cnt", {24'd0, stall_cnt}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    #1 rst_n = 1'b1;
    step("rst_alu", 1, 4'd5, 1, 0, 16'h1234, 1, 16'h9999, 0);
    check("rst_alu_wc", {28'd0, wc}, 32'd5);
    check("rst_alu_wrb", {31'd0, w_rb}, 32'd1);
    check("rst_alu_wdata", {16'd0, wdata}, 32'h1234);
    check("rst_alu_stall", {31'd0, stall}, 32'd0);

    // Register 0 write
    step("r0", 1, 4'd0, 1, 0, 16'h4321, 0, 16'h0, 0);
`ifdef EX_WB_R0_SUPPRESS_EN
    check("r0_wrb", {31'd0, w_rb}, 32'd0);
`else
    check("r0_wrb", {31'd0, w_rb}, 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           16'($urandom),
           ($urandom_range(0, 2) == 0),
           16'($urandom),
           ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 SHALL have parameter DW, default 16, data word width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port IN_VALID  input  1  EX stage presents an instruction this cycle.
REQ-005 SHALL have port IN_WC  input  4  destination register index.
REQ-006 SHALL have port IN_WE  input  1  instruction writes the register file.
REQ-007 SHALL have port IN_LOAD  input  1  result comes from memory, not ALU.
REQ-008 SHALL have port IN_RES  input  DW  ALU result.
REQ-009 SHALL have port MEM_RDY  input  1  memory read data valid this cycle.
REQ-010 SHALL have port MEM_DATA  input  DW  memory read data.
REQ-011 SHALL have port FLUSH  input  1  synchronous pipeline flush.
REQ-012 SHALL have port STALL  output  1  upstream must hold its instruction.
REQ-013 SHALL have ports WC  output  4 and W_RB  output  1: writeback index and enable, consumed by register file and forward unit.
REQ-014 SHALL have port WDATA  output  DW  writeback data.
REQ-015 SHALL have port STALL_CNT  output  8  count of stalled cycles.

Function
REQ-016 SHALL implement states IDLE, ALU, WAIT, LOADED, with WC/W_RB/WDATA registered, never combinational from inputs.
REQ-017 SHALL accept input on an edge when STALL=0: IN_VALID=0 -> IDLE; IN_VALID=1 and (IN_LOAD=0 or IN_WE=0) -> ALU; IN_VALID=1, IN_LOAD=1, IN_WE=1 -> WAIT.
REQ-018 SHALL in ALU present WC=captured IN_WC, WDATA=captured IN_RES, W_RB=captured IN_WE (ALU writeback latency 1 cycle).
REQ-019 SHALL in WAIT drive STALL=1, W_RB=0, WC=captured index; on an edge with MEM_RDY=1 latch MEM_DATA into WDATA and go to LOADED; otherwise remain in WAIT.
REQ-020 SHALL in LOADED drive W_RB=1, STALL=0, and leave LOADED on the next edge per REQ-017.
REQ-021 SHALL drive STALL=0 in IDLE, ALU and LOADED; STALL is a pure function of state.
REQ-022 SHALL ignore MEM_RDY outside WAIT.
REQ-023 SHALL give FLUSH priority over all other inputs: next state IDLE, W_RB=0, pending load abandoned even if MEM_RDY=1 on the same edge.
REQ-024 SHALL hold W_RB=0 in IDLE; WC and WDATA retain last value in IDLE.
REQ-025 SHALL increment STALL_CNT on each edge where STALL=1 and FLUSH=0, saturating at 255 (no wrap).

Reset
REQ-026 SHALL on rst_n=0, asynchronously and regardless of clk: state IDLE, WC=0, W_RB=0, WDATA=0, STALL_CNT=0, STALL=0.
REQ-027 SHALL on reset asserted mid-WAIT abandon the load; first edge after release behaves as from IDLE.

Configuration
REQ-028 SHALL, with macro EX_WB_R0_SUPPRESS_EN defined, force W_RB=0 whenever WC=0 (register 0 never written or forwarded); all other timing unchanged.
REQ-029 SHALL, without EX_WB_R0_SUPPRESS_EN, treat register 0 like any other index.

Verification
REQ-030 SHALL test ALU path: IN_VALID=1, IN_WE=1, IN_LOAD=0, IN_WC=5, IN_RES=0x1234 -> next cycle WC=5, W_RB=1, WDATA=0x1234, STALL=0.
REQ-031 SHALL test load with 3-cycle memory delay: IN_LOAD=1, IN_WE=1, IN_WC=7, MEM_RDY=1 on 3rd WAIT cycle with MEM_DATA=0xBEEF -> STALL=1 for 3 cycles, W_RB=0 throughout, then one cycle W_RB=1, WDATA=0xBEEF, STALL_CNT=3.
REQ-032 SHALL test FLUSH and MEM_RDY on same edge in WAIT -> next state IDLE, W_RB=0, WDATA unchanged.
REQ-033 SHALL test STALL_CNT saturation: hold WAIT with MEM_RDY=0 for 300 cycles -> STALL_CNT=255.
REQ-034 SHALL test rst_n pulsed low mid-WAIT between clock edges -> outputs zero immediately; after release, ALU instruction behaves per REQ-030.
REQ-035 SHALL test, with EX_WB_R0_SUPPRESS_EN defined, ALU write IN_WC=0, IN_WE=1 -> W_RB=0; without the macro -> W_RB=1.
